sipo_rx_ctrl: RTL and testbench
===============================

SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word length in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL have parameter CONTINUOUS, default 0; 1 means back-to-back words without a new frame_start.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port frame_start, input, 1 bit: single-cycle pulse marking the start of a word.
REQ-006 The block SHALL have port bit_valid, input, 1 bit: serial bit present on the companion shift register's serial input this cycle.
REQ-007 The block SHALL have port sipo_shift_en, output, 1 bit: shift enable to the companion MSB-first shift register.
REQ-008 The block SHALL have port sipo_data, input, WIDTH bits: parallel contents of the companion shift register.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: captured word.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data this cycle.
REQ-012 The block SHALL have port bit_cnt, output, $clog2(WIDTH) bits: bits received in the current word.
REQ-013 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-014 The block SHALL have ports overrun and sync_err, outputs, 1 bit each: sticky error flags.
REQ-015 The block SHALL have port err_clr, input, 1 bit: clears both sticky flags.

Function
REQ-016 The block SHALL implement the states IDLE, SHIFT and CAPTURE.
REQ-017 sipo_shift_en SHALL be combinational and equal to bit_valid when any of these holds: state is SHIFT; state is IDLE with frame_start high; state is CAPTURE with CONTINUOUS=1 or frame_start high. It SHALL be 0 in all other cases and whenever rst_n is low.
REQ-018 In IDLE, a cycle with frame_start high SHALL move the state to SHIFT, with bit_cnt becoming 1 if bit_valid is high and 0 otherwise.
REQ-019 In IDLE, a cycle with frame_start low SHALL leave the state and bit_cnt unchanged and SHALL ignore bit_valid.
REQ-020 In SHIFT, each cycle with bit_valid high SHALL increment bit_cnt; a cycle with bit_valid low SHALL hold all state.
REQ-021 In SHIFT, a cycle with bit_valid high and bit_cnt = WIDTH-1 SHALL move the state to CAPTURE and reset bit_cnt to 0.
REQ-022 In SHIFT, a cycle with frame_start high SHALL discard the partial word, set sync_err, and reset bit_cnt to 0, or to 1 if bit_valid is also high.
REQ-023 The resync in REQ-022 SHALL take priority over REQ-021 and SHALL keep the state in SHIFT.
REQ-024 CAPTURE SHALL last exactly one cycle, during which sipo_data is sampled.
REQ-025 In CAPTURE, if out_valid is 0 or out_ready is 1, out_data SHALL load sipo_data and out_valid SHALL be 1 on the next cycle.
REQ-026 In CAPTURE, if out_valid is 1 and out_ready is 0, the word SHALL be dropped, out_data SHALL be held, and overrun SHALL be set.
REQ-027 On leaving CAPTURE, the next state SHALL be SHIFT if CONTINUOUS=1 or frame_start is high, otherwise IDLE. bit_cnt SHALL become 1 if sipo_shift_en is high, otherwise 0. sync_err SHALL NOT be set by this transition.
REQ-028 out_valid SHALL fall on the cycle after out_ready is sampled high, unless a capture occurs in that same cycle.
REQ-029 out_data SHALL remain stable while out_valid is 1 and out_ready is 0.
REQ-030 End-to-end latency SHALL be as follows: the last bit is sampled at edge E, and out_valid=1 with the new out_data is visible after edge E+1.
REQ-031 When err_clr is high in the same cycle as an error set condition, the set SHALL win.

Reset
REQ-032 While rst_n is low at a clock edge, the state SHALL become IDLE, bit_cnt 0, out_data 0, out_valid 0, overrun 0 and sync_err 0.
REQ-033 Reset SHALL override every input, including a partial frame in progress and a pending word. No word captured before reset SHALL appear after reset.

Verification (WIDTH=8, CONTINUOUS=0 unless stated)
REQ-034 Basic word: frame_start together with the first bit, then 8 consecutive bits 1,0,1,1,0,0,1,0 with out_ready=1 -> out_data=8'hB2 and out_valid high for exactly 1 cycle, one edge after the last bit; the state then returns to IDLE.
REQ-035 Gapped bits: the same 8 bits with bit_valid low for 3 cycles between bits 4 and 5 -> bit_cnt holds at 4 through the gap, out_data=8'hB2, and sync_err stays 0.
REQ-036 Backpressure: two words 8'hB2 then 8'h5A with out_ready=0 throughout -> out_data stays 8'hB2, overrun=1; then err_clr -> overrun=0.
REQ-037 Resync: frame_start after 5 bits, then 8 bits of 8'hC3 -> sync_err=1, bit_cnt restarts, and out_data=8'hC3 only.
REQ-038 Continuous: CONTINUOUS=1, one frame_start, then 16 back-to-back bits of 8'hA5 and 8'h3C with out_ready=1 -> two words 8'hA5 then 8'h3C, with no bit lost during CAPTURE.
REQ-039 Reset mid-frame: rst_n low for 1 cycle after 4 bits, then a full frame of 8'h81 -> all outputs are 0 after reset, and the next word is 8'h81.

Source files
------------

// File: rtl/sipo_rx_ctrl.sv
// rtl/sipo_rx_ctrl.sv - control FSM for an external MSB-first SIPO shift register
// Counts incoming bits, captures each finished word into a one-deep output register, flags errors.
module sipo_rx_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     bit_valid,
  output logic                     sipo_shift_en,
  input  logic [WIDTH-1:0]         sipo_data,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     busy,
  output logic                     overrun,
  output logic                     sync_err,
  input  logic                     err_clr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          shift_en;
  logic          sync_set;
  logic          capture_ok;
  logic          overrun_set;

  assign capture_ok  = (state == CAPTURE) && (!out_valid || out_ready);
  assign overrun_set = (state == CAPTURE) && out_valid && !out_ready;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_en  = 1'b0;
    sync_set  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          shift_en  = bit_valid;
          state_nxt = SHIFT;
          cnt_nxt   = bit_valid ? CNT_ONE : '0;
        end
      end
      SHIFT: begin
        shift_en = bit_valid;
        // A new frame_start restarts the word even if this bit would have completed it.
        if (frame_start) begin
          sync_set = 1'b1;
          cnt_nxt  = bit_valid ? CNT_ONE : '0;
        end else if (bit_valid) begin
          if (bit_cnt == CNT_LAST) begin
            state_nxt = CAPTURE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = bit_cnt + CNT_ONE;
          end
        end
      end
      CAPTURE: begin
        if (CONTINUOUS || frame_start) begin
          shift_en  = bit_valid;
          state_nxt = SHIFT;
          cnt_nxt   = bit_valid ? CNT_ONE : '0;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign sipo_shift_en = shift_en && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      if (capture_ok) begin
        out_data  <= sipo_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (overrun_set) overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (sync_set) sync_err <= 1'b1;
      else if (err_clr) sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// tb/tb_sipo_rx_ctrl.sv - directed testbench for sipo_rx_ctrl
// Two instances (CONTINUOUS=0 and 1) share stimulus; each has its own shift register model.
module tb_sipo_rx_ctrl;

  logic clk = 1'b0;
  logic rst_n, frame_start, bit_valid, sbit, out_ready, err_clr;
  logic se0, se1, ov0, ov1, busy0, busy1, ovr0, ovr1, se_err0, se_err1;
  logic [7:0] sr0, sr1, od0, od1;
  logic [2:0] bc0, bc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_rx_ctrl #(.WIDTH(8), .CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid),
    .sipo_shift_en(se0), .sipo_data(sr0), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .bit_cnt(bc0), .busy(busy0), .overrun(ovr0),
    .sync_err(se_err0), .err_clr(err_clr));

  sipo_rx_ctrl #(.WIDTH(8), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid),
    .sipo_shift_en(se1), .sipo_data(sr1), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .bit_cnt(bc1), .busy(busy1), .overrun(ovr1),
    .sync_err(se_err1), .err_clr(err_clr));

  // Companion MSB-first shift registers
  always_ff @(posedge clk) begin
    if (!rst_n) sr0 <= '0;
    else if (se0) sr0 <= {sr0[6:0], sbit};
    if (!rst_n) sr1 <= '0;
    else if (se1) sr1 <= {sr1[6:0], sbit};
  end

  typedef struct {
    logic       fs, bv, b;
    logic       exp_se;
    logic [2:0] exp_cnt;
    logic       exp_busy, exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt[10];
  logic [7:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic fs, input logic bv, input logic b);
    frame_start = fs;
    bit_valid   = bv;
    sbit        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) cyc(i == 7, 1'b1, w[i]);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; bit_valid = 1'b0; sbit = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    do_reset();
    chk("reset_valid", {31'd0, ov0}, 0);
    chk("reset_data", {24'd0, od0}, 0);
    chk("reset_busy", {31'd0, busy0}, 0);
    chk("reset_cnt", {29'd0, bc0}, 0);

    // Basic word 8'hB2 with out_ready=1
    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 8'h00};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'h00};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 8'h00};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 8'h00};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 8'h00};
    vt[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 8'h00};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'hB2};
    vt[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hB2};
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      frame_start = vt[k].fs; bit_valid = vt[k].bv; sbit = vt[k].b;
      #1;
      chk($sformatf("basic_se[%0d]", k), {31'd0, se0}, {31'd0, vt[k].exp_se});
      @(posedge clk);
      #1;
      chk($sformatf("basic_cnt[%0d]", k), {29'd0, bc0}, {29'd0, vt[k].exp_cnt});
      chk($sformatf("basic_busy[%0d]", k), {31'd0, busy0}, {31'd0, vt[k].exp_busy});
      chk($sformatf("basic_valid[%0d]", k), {31'd0, ov0}, {31'd0, vt[k].exp_valid});
      chk($sformatf("basic_data[%0d]", k), {24'd0, od0}, {24'd0, vt[k].exp_data});
    end

    // Gapped bits
    do_reset();
    out_ready = 1'b1;
    cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1);
    for (int g = 0; g < 3; g++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk($sformatf("gap_cnt[%0d]", g), {29'd0, bc0}, 4);
    end
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("gap_valid", {31'd0, ov0}, 1);
    chk("gap_data", {24'd0, od0}, 32'hB2);
    chk("gap_sync_err", {31'd0, se_err0}, 0);

    // Backpressure and overrun
    do_reset();
    out_ready = 1'b0;
    send_word(8'hB2); cyc(1'b0, 1'b0, 1'b0);
    chk("bp_valid1", {31'd0, ov0}, 1);
    chk("bp_data1", {24'd0, od0}, 32'hB2);
    chk("bp_ovr1", {31'd0, ovr0}, 0);
    send_word(8'h5A); cyc(1'b0, 1'b0, 1'b0);
    chk("bp_data2", {24'd0, od0}, 32'hB2);
    chk("bp_ovr2", {31'd0, ovr0}, 1);
    err_clr = 1'b1; cyc(1'b0, 1'b0, 1'b0); err_clr = 1'b0;
    chk("bp_clr", {31'd0, ovr0}, 0);
    err_clr = 1'b1; send_word(8'h0F); cyc(1'b0, 1'b0, 1'b0); err_clr = 1'b0;
    chk("bp_set_wins", {31'd0, ovr0}, 1);
    chk("bp_data3", {24'd0, od0}, 32'hB2);
    out_ready = 1'b1; cyc(1'b0, 1'b0, 1'b0);
    chk("bp_drain", {31'd0, ov0}, 0);

    // Resync after 5 bits
    do_reset();
    out_ready = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("rs_cnt5", {29'd0, bc0}, 5);
    chk("rs_sync0", {31'd0, se_err0}, 0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("rs_sync1", {31'd0, se_err0}, 1);
    chk("rs_cnt1", {29'd0, bc0}, 1);
    begin
      logic [7:0] w;
      w = 8'hC3;
      for (int i = 6; i >= 0; i--) cyc(1'b0, 1'b1, w[i]);
    end
    chk("rs_no_early", {31'd0, ov0}, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rs_valid", {31'd0, ov0}, 1);
    chk("rs_data", {24'd0, od0}, 32'hC3);

    // Continuous mode, dut1
    do_reset();
    out_ready = 1'b1;
    got.delete();
    begin
      logic [15:0] bits;
      bits = 16'hA53C;
      for (int i = 15; i >= 0; i--) begin
        cyc(i == 15, 1'b1, bits[i]);
        if (ov1) got.push_back(od1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (ov1) got.push_back(od1);
    end
    chk("cont_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("cont_word0", {24'd0, got[0]}, 32'hA5);
      chk("cont_word1", {24'd0, got[1]}, 32'h3C);
    end
    chk("cont_sync_err", {31'd0, se_err1}, 0);

    // Reset mid-frame with a pending word
    do_reset();
    out_ready = 1'b0;
    send_word(8'hB2); cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0; frame_start = 1'b0; bit_valid = 1'b1; sbit = 1'b1;
    #1;
    chk("mr_se_in_reset", {31'd0, se0}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mr_valid", {31'd0, ov0}, 0);
    chk("mr_data", {24'd0, od0}, 0);
    chk("mr_cnt", {29'd0, bc0}, 0);
    chk("mr_busy", {31'd0, busy0}, 0);
    chk("mr_flags", {30'd0, ovr0, se_err0}, 0);
    out_ready = 1'b1;
    send_word(8'h81); cyc(1'b0, 1'b0, 1'b0);
    chk("mr_next_valid", {31'd0, ov0}, 1);
    chk("mr_next_data", {24'd0, od0}, 32'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
